glitch_outcome_monitor: RTL

- Downstream of the glitch pulse generator.
- Each time a glitch completes, it watches the target's heartbeat and fault-flag pins for a fixed window. It classifies the attempt as NORMAL, SUCCESS or CRASH.
- Keeps saturating per-outcome tallies.
- Power-cycles the target through `pow` after a crash, then holds off until the target has rebooted.

---
 rtl/glitch_pkg.sv | 31 +++
 rtl/glitch_outcome_monitor_sync_edge.sv | 35 +++
 rtl/glitch_outcome_monitor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch attack chain (glitcher + outcome monitor).
//   TMR_W     : width of every cycle timer in the chain
//   state_t   : outcome monitor FSM encoding
//   RES_*     : result codes as seen on the monitor's result port
//   classify  : maps the observation flags to a result code
package glitch_pkg;

  localparam int TMR_W = 28;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OBSERVE   = 3'd1,
    ST_REPORT    = 3'd2,
    ST_POWER_OFF = 3'd3,
    ST_REBOOT    = 3'd4
  } state_t;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_NORMAL  = 2'd1;
  localparam logic [1:0] RES_SUCCESS = 2'd2;
  localparam logic [1:0] RES_CRASH   = 2'd3;

  // A fault flag outranks a heartbeat: a target that computed a wrong
  // result and kept running is still a successful glitch.
  function automatic logic [1:0] classify(input logic seen_fault, input logic seen_hb);
    if (seen_fault)   return RES_SUCCESS;
    else if (seen_hb) return RES_NORMAL;
    else              return RES_CRASH;
  endfunction

endpackage

// File: rtl/glitch_outcome_monitor_sync_edge.sv
// Two-flop synchroniser followed by an edge-history flop.
//   clk  : clock
//   rst  : synchronous active-high reset, clears all three flops
//   d    : asynchronous input
//   rise : synced 0->1 (combinational from the flops, 2 cycles after d)
//   fall : synced 1->0
//   any  : either transition
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic any
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;
  assign any  = s2 ^ prev;

endmodule

// File: rtl/glitch_outcome_monitor.sv
// Classifies each glitch attempt from the target's heartbeat and fault pins,
// keeps saturating per-outcome tallies and power-cycles the target after a crash.
//   clk, rst       : clock, synchronous active-high reset
//   glitch_done    : one-cycle pulse when a glitch pulse ends
//   tgt_hb         : async target heartbeat (any toggle = alive)
//   tgt_fault      : async target fault flag (rise = wrong result computed)
//   pow            : target power enable, 1 = powered
//   busy           : monitor not idle
//   result_valid   : one-cycle classification strobe
//   result         : classification (held until the next strobe)
//   n_normal/n_success/n_crash/n_dropped : saturating tallies
//   led_success    : sticky success indicator
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | waiting for glitch_done
// OBSERVE    | watching heartbeat/fault for up to WINDOW cycles
// REPORT     | one cycle: strobe result, bump tally
// POWER_OFF  | pow low for PWR_OFF_CYC cycles (after a crash only)
// REBOOT     | pow high, waiting BOOT_CYC cycles for the target to boot
module glitch_outcome_monitor
  import glitch_pkg::*;
#(
  parameter int unsigned WINDOW      = 12000000,
  parameter int unsigned PWR_OFF_CYC = 2400000,
  parameter int unsigned BOOT_CYC    = 24000000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             glitch_done,
  input  logic             tgt_hb,
  input  logic             tgt_fault,
  output logic             pow,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] n_normal,
  output logic [CNT_W-1:0] n_success,
  output logic [CNT_W-1:0] n_crash,
  output logic [CNT_W-1:0] n_dropped,
  output logic             led_success
);

  if (WINDOW == 0 || 64'(WINDOW) >= (64'd1 << TMR_W) ||
      PWR_OFF_CYC == 0 || 64'(PWR_OFF_CYC) >= (64'd1 << TMR_W) ||
      BOOT_CYC == 0 || 64'(BOOT_CYC) >= (64'd1 << TMR_W)) begin : g_bad_timer_param
    $error("glitch_outcome_monitor: timer parameters must be in 1 .. 2**%0d-1", TMR_W);
  end

  localparam logic [TMR_W-1:0] WIN_LAST  = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] PWR_LAST  = TMR_W'(PWR_OFF_CYC - 1);
  localparam logic [TMR_W-1:0] BOOT_LAST = TMR_W'(BOOT_CYC - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] win_cnt;
  logic [TMR_W-1:0] tmr;
  logic             seen_hb, seen_fault;
  logic [1:0]       result_q;
  logic [1:0]       outcome;

  logic hb_rise, hb_fall, hb_any;
  logic flt_rise, flt_fall, flt_any;

  sync_edge u_sync_hb (
    .clk  (clk),
    .rst  (rst),
    .d    (tgt_hb),
    .rise (hb_rise),
    .fall (hb_fall),
    .any  (hb_any)
  );

  sync_edge u_sync_fault (
    .clk  (clk),
    .rst  (rst),
    .d    (tgt_fault),
    .rise (flt_rise),
    .fall (flt_fall),
    .any  (flt_any)
  );

  assign outcome = classify(seen_fault, seen_hb);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != ST_IDLE);
    pow          = (state != ST_POWER_OFF);
    result_valid = (state == ST_REPORT);
    // The strobe cycle shows the fresh classification; result_q takes it
    // over on the following edge so the port holds steady afterwards.
    result       = result_valid ? outcome : result_q;
    case (state)
      ST_IDLE:      if (glitch_done) state_nxt = ST_OBSERVE;
      ST_OBSERVE:   if (flt_rise || win_cnt == WIN_LAST) state_nxt = ST_REPORT;
      ST_REPORT:    state_nxt = (outcome == RES_CRASH) ? ST_POWER_OFF : ST_IDLE;
      ST_POWER_OFF: if (tmr == '0) state_nxt = ST_REBOOT;
      ST_REBOOT:    if (tmr == '0) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      tmr         <= '0;
      seen_hb     <= 1'b0;
      seen_fault  <= 1'b0;
      result_q    <= RES_NONE;
      n_normal    <= '0;
      n_success   <= '0;
      n_crash     <= '0;
      n_dropped   <= '0;
      led_success <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (glitch_done) begin
            win_cnt    <= '0;
            seen_hb    <= 1'b0;
            seen_fault <= 1'b0;
          end
        end
        ST_OBSERVE: begin
          win_cnt <= win_cnt + 1'b1;
          if (hb_any)   seen_hb    <= 1'b1;
          if (flt_rise) seen_fault <= 1'b1;
        end
        ST_REPORT: begin
          result_q <= outcome;
          tmr      <= PWR_LAST;
          case (outcome)
            RES_NORMAL:  if (n_normal  != '1) n_normal  <= n_normal  + 1'b1;
            RES_SUCCESS: if (n_success != '1) n_success <= n_success + 1'b1;
            default:     if (n_crash   != '1) n_crash   <= n_crash   + 1'b1;
          endcase
          if (outcome == RES_SUCCESS) led_success <= 1'b1;
        end
        ST_POWER_OFF: begin
          if (tmr == '0) tmr <= BOOT_LAST;
          else           tmr <= tmr - 1'b1;
        end
        ST_REBOOT: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
        end
        default: ;
      endcase

      if (glitch_done && state != ST_IDLE && n_dropped != '1)
        n_dropped <= n_dropped + 1'b1;
    end
  end

endmodule
